led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 97 +++++++++
 tb/tb_led_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: timed LED item display and all-LED end-of-game flash
module led_sequencer #(
  parameter int DATA_WIDTH  = 4,
  parameter int ON_SLOW     = 8,
  parameter int ON_FAST     = 4,
  parameter int GAP         = 2,
  parameter int BLINK       = 4,
  parameter int BLINK_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  show_req,
  input  logic [DATA_WIDTH-1:0] show_item,
  input  logic                  speed,
  input  logic                  flash_req,
  output logic [DATA_WIDTH-1:0] leds,
  output logic                  ready,
  output logic                  show_done,
  output logic                  flash_done
);
  localparam int M0  = ON_SLOW > ON_FAST ? ON_SLOW : ON_FAST;
  localparam int M1  = GAP > BLINK ? GAP : BLINK;
  localparam int MX  = M0 > M1 ? M0 : M1;
  localparam int CW  = $clog2(MX + 1);
  localparam int PW  = $clog2(BLINK_COUNT + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHOW_ON   = 3'd1;
  localparam logic [2:0] SHOW_GAP  = 3'd2;
  localparam logic [2:0] FLASH_ON  = 3'd3;
  localparam logic [2:0] FLASH_OFF = 3'd4;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pair;
  assign ready = state == IDLE;
  // State walk: each phase loads cnt with its length-1 and advances when cnt hits 0.
  // The latched item lives in leds itself, so no separate item/speed registers are needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pair       <= '0;
      leds       <= '0;
      show_done  <= 1'b0;
      flash_done <= 1'b0;
    end else begin
      show_done  <= 1'b0;
      flash_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flash_req) begin
            state <= FLASH_ON;
            leds  <= '1;
            cnt   <= CW'(BLINK - 1);
            pair  <= PW'(BLINK_COUNT - 1);
          end else if (show_req) begin
            state <= SHOW_ON;
            leds  <= show_item;
            cnt   <= speed ? CW'(ON_FAST - 1) : CW'(ON_SLOW - 1);
          end
        end
        SHOW_ON: begin
          if (cnt == '0) begin
            state <= SHOW_GAP;
            leds  <= '0;
            cnt   <= CW'(GAP - 1);
          end else cnt <= cnt - CW'(1);
        end
        SHOW_GAP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            show_done <= 1'b1;
          end else cnt <= cnt - CW'(1);
        end
        FLASH_ON: begin
          if (cnt == '0) begin
            state <= FLASH_OFF;
            leds  <= '0;
            cnt   <= CW'(BLINK - 1);
          end else cnt <= cnt - CW'(1);
        end
        FLASH_OFF: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (pair == '0) begin
            state      <= IDLE;
            flash_done <= 1'b1;
          end else begin
            state <= FLASH_ON;
            leds  <= '1;
            cnt   <= CW'(BLINK - 1);
            pair  <= pair - PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and random checks of led_sequencer against a per-cycle plan model
module tb_led_sequencer;
  localparam int ON_SLOW = 8, ON_FAST = 4, GAP = 2, BLINK = 4, BLINK_COUNT = 3;
  typedef struct packed {
    logic [3:0] leds;
    logic       rdy;
    logic       sd;
    logic       fd;
  } exp_t;
  localparam exp_t IDLE_E = '{leds: 4'h0, rdy: 1'b1, sd: 1'b0, fd: 1'b0};
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       show_req = 1'b0;
  logic [3:0] show_item = 4'h0;
  logic       speed = 1'b0;
  logic       flash_req = 1'b0;
  logic [3:0] leds;
  logic       ready, show_done, flash_done;
  int         errors = 0;
  int         checks = 0;
  exp_t       cur = IDLE_E;
  exp_t       plan[$];

  led_sequencer dut (
    .clk(clk), .rst_n(rst_n), .show_req(show_req), .show_item(show_item),
    .speed(speed), .flash_req(flash_req), .leds(leds), .ready(ready),
    .show_done(show_done), .flash_done(flash_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("leds", leds, cur.leds);
    chk("ready", {3'b0, ready}, {3'b0, cur.rdy});
    chk("show_done", {3'b0, show_done}, {3'b0, cur.sd});
    chk("flash_done", {3'b0, flash_done}, {3'b0, cur.fd});
  endtask

  task automatic plan_show(input logic [3:0] it, input logic sp);
    int n = sp ? ON_FAST : ON_SLOW;
    for (int i = 0; i < n; i++) plan.push_back('{leds: it, rdy: 1'b0, sd: 1'b0, fd: 1'b0});
    for (int i = 0; i < GAP; i++) plan.push_back('{leds: 4'h0, rdy: 1'b0, sd: 1'b0, fd: 1'b0});
    plan.push_back('{leds: 4'h0, rdy: 1'b1, sd: 1'b1, fd: 1'b0});
  endtask

  task automatic plan_flash();
    for (int p = 0; p < BLINK_COUNT; p++) begin
      for (int i = 0; i < BLINK; i++) plan.push_back('{leds: 4'hF, rdy: 1'b0, sd: 1'b0, fd: 1'b0});
      for (int i = 0; i < BLINK; i++) plan.push_back('{leds: 4'h0, rdy: 1'b0, sd: 1'b0, fd: 1'b0});
    end
    plan.push_back('{leds: 4'h0, rdy: 1'b1, sd: 1'b0, fd: 1'b1});
  endtask

  task automatic cycle();
    if (rst_n && cur.rdy) begin
      if (flash_req) plan_flash();
      else if (show_req) plan_show(show_item, speed);
    end
    @(posedge clk);
    #1;
    if (!rst_n) plan.delete();
    if (plan.size() == 0) cur = IDLE_E;
    else cur = plan.pop_front();
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #1;
    check_all();
    run(3);
    rst_n = 1'b1;
    run(2);
    show_item = 4'b0010; speed = 1'b0; show_req = 1'b1;
    cycle();
    show_req = 1'b0; show_item = 4'hF;
    run(12);
    show_item = 4'b1000; speed = 1'b1; show_req = 1'b1;
    cycle();
    show_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      speed = ~speed;
      cycle();
    end
    flash_req = 1'b1;
    cycle();
    flash_req = 1'b0;
    run(27);
    show_item = 4'b0110; speed = 1'b0; show_req = 1'b1; flash_req = 1'b1;
    cycle();
    show_req = 1'b0; flash_req = 1'b0;
    run(5);
    show_req = 1'b1;
    cycle();
    show_req = 1'b0;
    run(22);
    show_item = 4'b0101; speed = 1'b0; show_req = 1'b1;
    cycle();
    show_req = 1'b0;
    run(2);
    rst_n = 1'b0;
    #1;
    plan.delete();
    cur = IDLE_E;
    check_all();
    run(2);
    rst_n = 1'b1;
    show_item = 4'b0011; speed = 1'b1; show_req = 1'b1;
    cycle();
    show_item = 4'b1100;
    run(8);
    speed = 1'b0;
    run(10);
    show_req = 1'b0;
    run(12);
    show_item = 4'b0000; speed = 1'b1; show_req = 1'b1;
    cycle();
    show_req = 1'b0;
    run(8);
    for (int i = 0; i < 400; i++) begin
      show_req  = ($urandom_range(0, 3) == 0);
      flash_req = ($urandom_range(0, 15) == 0);
      show_item = 4'($urandom);
      speed     = 1'($urandom);
      cycle();
    end
    show_req = 1'b0; flash_req = 1'b0;
    run(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
